// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between the decoder/EX stage and the
// iterative RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             busy;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;

    // Issuing side: decoder/pipeline
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, flush, resp_ready,
        input  req_ready, busy, resp_valid, resp_data, resp_tag
    );

    // Executing side: the sequencer
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, flush, resp_ready,
        output req_ready, busy, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M MUL*/DIV*/REM* unit. Shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign fix-up on
// the final step.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed divide overflow
// and multiply-by-zero skip CALC and respond straight from DONE.
module muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(XLEN);
    localparam int unsigned PROD_W = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             b_zero_q, b_zero_d;
    logic [XLEN-1:0]  a_orig_q, a_orig_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;      // multiplicand |a| or divisor |b|
    logic [XLEN-1:0]  hi_q, hi_d;          // product high half / remainder
    logic [XLEN-1:0]  lo_q, lo_d;          // multiplier->product low / dividend->quotient
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    logic             req_sa_c, req_sb_c;
    logic [XLEN-1:0]  mag_a_c, mag_b_c;
    logic             early_c;
    logic [XLEN-1:0]  early_data_c;
    logic [XLEN:0]    mul_sum_c, div_shift_c, div_diff_c;
    logic [XLEN-1:0]  step_hi_c, step_lo_c;
    logic [PROD_W-1:0] prod_raw_c, prod_c;
    logic [XLEN-1:0]  result_c;

    // Request decode: operand signedness and magnitudes
    always_comb begin
        req_sa_c = 1'b0;
        req_sb_c = 1'b0;
        unique case (bus.req_op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                req_sa_c = bus.req_a[XLEN-1];
                req_sb_c = bus.req_b[XLEN-1];
            end
            OP_MULHSU: req_sa_c = bus.req_a[XLEN-1];
            default: ;
        endcase
        mag_a_c = req_sa_c ? -bus.req_a : bus.req_a;
        mag_b_c = req_sb_c ? -bus.req_b : bus.req_b;
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Trivial results resolved at accept time
    always_comb begin
        early_c      = 1'b0;
        early_data_c = '0;
        if (bus.req_op[2]) begin
            if (bus.req_b == '0) begin
                early_c      = 1'b1;
                early_data_c = bus.req_op[1] ? bus.req_a : '1;
            end else if (!bus.req_op[0] && (bus.req_a == {1'b1, {(XLEN-1){1'b0}}})
                         && (bus.req_b == '1)) begin
                early_c      = 1'b1;
                early_data_c = bus.req_op[1] ? '0 : bus.req_a;
            end
        end else if ((bus.req_a == '0) || (bus.req_b == '0)) begin
            early_c = 1'b1;
        end
    end
`else
    assign early_c      = 1'b0;
    assign early_data_c = '0;
`endif

    // One iteration: shift-add multiply step or restoring divide step
    always_comb begin
        mul_sum_c   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        div_shift_c = {hi_q, lo_q[XLEN-1]};
        div_diff_c  = div_shift_c - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff_c[XLEN]) begin
                step_hi_c = div_diff_c[XLEN-1:0];
                step_lo_c = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi_c = div_shift_c[XLEN-1:0];
                step_lo_c = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi_c = mul_sum_c[XLEN:1];
            step_lo_c = {mul_sum_c[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result select applied to the last iteration's output
    always_comb begin
        prod_raw_c = {step_hi_c, step_lo_c};
        prod_c     = (sign_a_q ^ sign_b_q) ? -prod_raw_c : prod_raw_c;
        if (!op_q[2]) begin
            result_c = (op_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[PROD_W-1:XLEN];
        end else if (b_zero_q) begin
            result_c = op_q[1] ? a_orig_q : '1;
        end else if (op_q[1]) begin
            result_c = sign_a_q ? -step_hi_c : step_hi_c;
        end else begin
            result_c = (sign_a_q ^ sign_b_q) ? -step_lo_c : step_lo_c;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        op_d         = op_q;
        tag_d        = tag_q;
        sign_a_d     = sign_a_q;
        sign_b_d     = sign_b_q;
        b_zero_d     = b_zero_q;
        a_orig_d     = a_orig_q;
        opnd_d       = opnd_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!bus.flush && bus.req_valid) begin
                    op_d     = bus.req_op;
                    tag_d    = bus.req_tag;
                    sign_a_d = req_sa_c;
                    sign_b_d = req_sb_c;
                    b_zero_d = (bus.req_b == '0);
                    a_orig_d = bus.req_a;
                    opnd_d   = bus.req_op[2] ? mag_b_c : mag_a_c;
                    lo_d     = bus.req_op[2] ? mag_a_c : mag_b_c;
                    hi_d     = '0;
                    count_d  = '0;
                    state_d  = ST_CALC;
                    if (early_c) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = early_data_c;
                        resp_tag_d   = bus.req_tag;
                    end
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    hi_d    = step_hi_c;
                    lo_d    = step_lo_c;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(XLEN - 1)) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = result_c;
                        resp_tag_d   = tag_q;
                    end
                end
            end
            ST_DONE: begin
                if (bus.flush || bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            b_zero_q     <= 1'b0;
            a_orig_q     <= '0;
            opnd_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            sign_a_q     <= sign_a_d;
            sign_b_q     <= sign_b_d;
            b_zero_q     <= b_zero_d;
            a_orig_q     <= a_orig_d;
            opnd_q       <= opnd_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE) && !bus.flush;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of muldiv_seq results, latency, handshake,
// flush and asynchronous reset.
module tb_muldiv_seq;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned TAG_W    = 5;
    localparam int          FULL_LAT = 32;   // edges from accept until resp_valid is seen
`ifdef MULDIV_EARLY_OUT_EN
    localparam int          EARLY_LAT = 0;
`else
    localparam int          EARLY_LAT = FULL_LAT;
`endif

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    muldiv_seq_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    muldiv_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int n = 0;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_op    = 3'($urandom);
        bus.req_tag   = 5'($urandom);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                          input bit early);
        int lat;
        issue(op, a, b, tag);
        wait_resp(lat);
        chk({name, "_lat"}, 32'(lat), 32'(early ? EARLY_LAT : FULL_LAT));
        chk({name, "_data"}, bus.resp_data, exp);
        chk({name, "_tag"}, 32'(bus.resp_tag), 32'(tag));
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk({name, "_drop"}, 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_tag    = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of MUL 7*3
        issue(3'b000, 32'd7, 32'd3, 5'd9);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        expect_quiet("midrst_no_stale", 40);

        // Multiply set
        run_op("mul_neg",   3'b000, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0);
        run_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 1'b0);
        run_op("mul_zero",  3'b000, 32'd0,         32'd12345,     5'd5,  32'd0,         1'b1);

        // Divide set
        run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 1'b0);
        run_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 1'b0);
        run_op("divu",      3'b101, 32'd100,       32'd7,         5'd8,  32'd14,        1'b0);
        run_op("remu",      3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         1'b0);
        run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1);
        run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1'b1);

        // Divide by zero
        run_op("div_by0",   3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1);
        run_op("rem_by0",   3'b110, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9, 1'b1);
        run_op("remu_by0",  3'b111, 32'd5,         32'd0,         5'd15, 32'd5,         1'b1);
        run_op("divn_by0",  3'b100, 32'hFFFF_FFF9, 32'd0,         5'd16, 32'hFFFF_FFFF, 1'b1);

        // Backpressure: hold the response for 10 cycles
        issue(3'b101, 32'd1000, 32'd9, 5'd17);
        wait_resp(lat);
        chk("bp_lat", 32'(lat), 32'(FULL_LAT));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_data", bus.resp_data, 32'd111);
            chk("bp_tag", 32'(bus.resp_tag), 32'd17);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("bp_release_valid", 32'(bus.resp_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        run_op("bp_next", 3'b000, 32'd6, 32'd7, 5'd18, 32'd42, 1'b0);

        // Flush at CALC count 10
        issue(3'b000, 32'd7, 32'd3, 5'd19);
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_calc_busy", 32'(bus.busy), 32'd0);
        chk("flush_calc_valid", 32'(bus.resp_valid), 32'd0);
        expect_quiet("flush_calc_quiet", 40);

        // Flush together with a request
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b000;
        bus.req_a     = 32'd3;
        bus.req_b     = 32'd3;
        bus.req_tag   = 5'd20;
        #1;
        chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        chk("flush_req_busy", 32'(bus.busy), 32'd0);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        expect_quiet("flush_req_quiet", 40);

        // Flush in DONE with resp_ready high
        issue(3'b101, 32'd100, 32'd7, 5'd21);
        wait_resp(lat);
        chk("flush_done_lat", 32'(lat), 32'(FULL_LAT));
        bus.flush      = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        chk("flush_done_valid", 32'(bus.resp_valid), 32'd0);
        chk("flush_done_busy", 32'(bus.busy), 32'd0);
        expect_quiet("flush_done_quiet", 5);
        run_op("after_flush", 3'b111, 32'd100, 32'd7, 5'd22, 32'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
